// File: rtl/sd_play_sched_if.sv
// Control bundle between the key/frame sources and the playback scheduler.
// Master drives key pulses and frame status; slave returns read-controller controls.
// No handshake: every signal is a level or a one-cycle pulse sampled on clk.
interface sd_play_sched_if;
  logic        key_play;
  logic        key_retro;
  logic        key_next;
  logic        key_prev;
  logic        frame_done;
  logic [7:0]  read_frame_cnt;
  logic [31:0] rd_addr_setting;
  logic        rd_addr_reset;
  logic        rd_stop;
  logic        rd_retro;
  logic [3:0]  file_idx;
  logic [1:0]  play_state;
  logic        cmd_pending;

  modport master (
    output key_play, key_retro, key_next, key_prev, frame_done, read_frame_cnt,
    input  rd_addr_setting, rd_addr_reset, rd_stop, rd_retro, file_idx, play_state, cmd_pending
  );

  modport slave (
    input  key_play, key_retro, key_next, key_prev, frame_done, read_frame_cnt,
    output rd_addr_setting, rd_addr_reset, rd_stop, rd_retro, file_idx, play_state, cmd_pending
  );
endinterface

// File: rtl/sd_play_sched.sv
// Playback scheduler: turns key pulses into frame-aligned read-controller controls.
// Latency: keys and frame boundaries take effect on the next clock edge; all outputs registered.
// No backpressure: mode keys are held in a single pending slot, newer overwrites older.
// Optional: SD_PLAY_AUTO_NEXT_EN advances to the next file at the end of a played file.
module sd_play_sched #(
  parameter int          FILE_NUM    = 4,
  parameter logic [31:0] FILE_BASE   = 32'd0,
  parameter logic [31:0] FILE_STRIDE = 32'd1481040,
  parameter int          FRAME_MAX   = 180
) (
  input logic           clk,
  input logic           rst,
  sd_play_sched_if.slave io
);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_RETRO  = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST_FILE  = 4'(FILE_NUM - 1);
`ifdef SD_PLAY_AUTO_NEXT_EN
  localparam logic [7:0] LP_LAST_FRAME = 8'(FRAME_MAX - 1);
`endif

  state_t      r_state;
  state_t      r_pend_tgt;
  logic        r_pend_vld;
  logic        r_sw_first;
  logic [3:0]  r_file_idx;
  logic [31:0] r_addr;
  logic        r_stop;
  logic        r_retro;
  logic        r_addr_reset;

  state_t      w_state_nxt;
  state_t      w_pend_tgt_nxt;
  state_t      w_base;
  state_t      w_tgt;
  logic        w_pend_vld_nxt;
  logic        w_sw_first_nxt;
  logic [3:0]  w_file_nxt;
  logic [31:0] w_addr_nxt;

  function automatic logic [31:0] f_addr(input logic [3:0] idx);
    return FILE_BASE + ({28'd0, idx} * FILE_STRIDE);
  endfunction

  function automatic logic [3:0] f_file_inc(input logic [3:0] idx);
    return (idx == LP_LAST_FILE) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] f_file_dec(input logic [3:0] idx);
    return (idx == 4'd0) ? LP_LAST_FILE : idx - 4'd1;
  endfunction

  // State, pending command, file selection and registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_PAUSE;
      r_pend_tgt   <= ST_PAUSE;
      r_pend_vld   <= 1'b0;
      r_sw_first   <= 1'b0;
      r_file_idx   <= 4'd0;
      r_addr       <= FILE_BASE;
      r_stop       <= 1'b1;
      r_retro      <= 1'b0;
      r_addr_reset <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_tgt   <= w_pend_tgt_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_sw_first   <= w_sw_first_nxt;
      r_file_idx   <= w_file_nxt;
      r_addr       <= w_addr_nxt;
      r_stop       <= (w_state_nxt == ST_PAUSE);
      r_retro      <= (w_state_nxt == ST_RETRO);
      r_addr_reset <= (w_state_nxt == ST_SWITCH);
    end
  end

  // Next state: file keys act at once, mode changes wait for a frame boundary.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_vld_nxt = r_pend_vld;
    w_sw_first_nxt = 1'b0;
    w_file_nxt     = r_file_idx;
    w_addr_nxt     = r_addr;

    // A mode key toggles relative to the latest intent; SWITCH always exits to PLAY.
    w_base = r_pend_vld ? r_pend_tgt : ((r_state == ST_SWITCH) ? ST_PLAY : r_state);
    if (io.key_play) begin
      w_tgt = (w_base == ST_PLAY) ? ST_PAUSE : ST_PLAY;
    end else begin
      w_tgt = (w_base == ST_RETRO) ? ST_PLAY : ST_RETRO;
    end

    if (io.key_next || io.key_prev) begin
      // Lower-priority mode keys this cycle are dropped; an older pending command survives.
      w_file_nxt     = io.key_next ? f_file_inc(r_file_idx) : f_file_dec(r_file_idx);
      w_addr_nxt     = f_addr(w_file_nxt);
      w_state_nxt    = ST_SWITCH;
      w_sw_first_nxt = 1'b1;
    end else begin
      if (r_state == ST_SWITCH) begin
        // The read controller sees the reload request one cycle late, so skip the first cycle.
        if (io.frame_done && !r_sw_first) begin
          w_state_nxt = ST_PLAY;
        end
      end else if (io.frame_done) begin
        if (r_pend_vld) begin
          w_state_nxt    = r_pend_tgt;
          w_pend_vld_nxt = 1'b0;
        end else if (r_state == ST_RETRO && io.read_frame_cnt == 8'd0) begin
          w_state_nxt = ST_PAUSE;
        end
`ifdef SD_PLAY_AUTO_NEXT_EN
        else if (r_state == ST_PLAY && io.read_frame_cnt == LP_LAST_FRAME) begin
          w_file_nxt = f_file_inc(r_file_idx);
          w_addr_nxt = f_addr(w_file_nxt);
        end
`endif
      end

      // A key on a boundary cycle lands after the old target was applied.
      if (io.key_play || io.key_retro) begin
        w_pend_vld_nxt = 1'b1;
        w_pend_tgt_nxt = w_tgt;
      end
    end
  end

  assign io.rd_addr_setting = r_addr;
  assign io.rd_addr_reset   = r_addr_reset;
  assign io.rd_stop         = r_stop;
  assign io.rd_retro        = r_retro;
  assign io.file_idx        = r_file_idx;
  assign io.play_state      = r_state;
  assign io.cmd_pending     = r_pend_vld;

endmodule

// File: tb/tb_sd_play_sched.sv
// Bench for sd_play_sched: directed scenarios followed by random key/frame traffic.
// Expected values come from a cycle-level behavioural model of the playback rules.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_sd_play_sched;
  localparam int     FILE_NUM  = 4;
  localparam longint BASE      = 0;
  localparam longint STRIDE    = 1481040;
  localparam int     FRAME_MAX = 180;

  localparam int PAUSE = 0, PLAY = 1, RETRO = 2, SWITCH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_play_sched_if u_if();

  sd_play_sched #(
    .FILE_NUM   (FILE_NUM),
    .FILE_BASE  (32'(BASE)),
    .FILE_STRIDE(32'(STRIDE)),
    .FRAME_MAX  (FRAME_MAX)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .io (u_if.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: playback mode, pending target (-1 = none), file, cycles spent in SWITCH.
  int m_state, m_pend, m_file, m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return 32'(BASE + longint'(m_file) * STRIDE);
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".state"},   32'(u_if.play_state),      32'(m_state));
    chk({ph, ".stop"},    32'(u_if.rd_stop),         32'(m_state == PAUSE));
    chk({ph, ".retro"},   32'(u_if.rd_retro),        32'(m_state == RETRO));
    chk({ph, ".areset"},  32'(u_if.rd_addr_reset),   32'(m_state == SWITCH));
    chk({ph, ".file"},    32'(u_if.file_idx),        32'(m_file));
    chk({ph, ".addr"},    u_if.rd_addr_setting,      exp_addr());
    chk({ph, ".pending"}, 32'(u_if.cmd_pending),     32'(m_pend >= 0));
  endtask

  task automatic model_reset();
    m_state = PAUSE;
    m_pend  = -1;
    m_file  = 0;
    m_age   = 0;
  endtask

  task automatic model_step(input bit kn, input bit kp, input bit kpl, input bit kr,
                            input bit fd, input int cnt);
    int old_state, old_pend, base;
    old_state = m_state;
    old_pend  = m_pend;
    if (kn || kp) begin
      m_file  = kn ? (m_file + 1) % FILE_NUM : (m_file + FILE_NUM - 1) % FILE_NUM;
      m_state = SWITCH;
      m_age   = 0;
    end else begin
      if (old_state == SWITCH) begin
        if (fd && m_age > 0) m_state = PLAY;
        m_age++;
      end else if (fd) begin
        if (old_pend >= 0) begin
          m_state = old_pend;
          m_pend  = -1;
        end else if (old_state == RETRO && cnt == 0) begin
          m_state = PAUSE;
        end
`ifdef SD_PLAY_AUTO_NEXT_EN
        else if (old_state == PLAY && cnt == FRAME_MAX - 1) begin
          m_file = (m_file + 1) % FILE_NUM;
        end
`endif
      end
      if (kpl || kr) begin
        base = (old_pend >= 0) ? old_pend : ((old_state == SWITCH) ? PLAY : old_state);
        if (kpl) m_pend = (base == PLAY) ? PAUSE : PLAY;
        else     m_pend = (base == RETRO) ? PLAY : RETRO;
      end
    end
  endtask

  task automatic cyc(input string ph, input bit kn, input bit kp, input bit kpl, input bit kr,
                     input bit fd, input int cnt);
    @(negedge clk);
    u_if.key_next       = kn;
    u_if.key_prev       = kp;
    u_if.key_play       = kpl;
    u_if.key_retro      = kr;
    u_if.frame_done     = fd;
    u_if.read_frame_cnt = 8'(cnt);
    @(posedge clk);
    #1;
    model_step(kn, kp, kpl, kr, fd, cnt);
    check_all(ph);
    u_if.key_next   = 1'b0;
    u_if.key_prev   = 1'b0;
    u_if.key_play   = 1'b0;
    u_if.key_retro  = 1'b0;
    u_if.frame_done = 1'b0;
  endtask

  initial begin
    bit kn, kp, kpl, kr, fd;
    int kind, cnt;

    rst = 1'b1;
    u_if.key_next = 1'b0; u_if.key_prev = 1'b0; u_if.key_play = 1'b0;
    u_if.key_retro = 1'b0; u_if.frame_done = 1'b0; u_if.read_frame_cnt = 8'd0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 0, 0, 0, 0);
    chk("rst_stop", 32'(u_if.rd_stop), 32'd1);
    chk("rst_addr", u_if.rd_addr_setting, 32'd0);

    // Play key mid-frame waits for the boundary.
    cyc("play_key", 0, 0, 1, 0, 0, 0);
    chk("play_pend", 32'(u_if.cmd_pending), 32'd1);
    chk("play_stop_held", 32'(u_if.rd_stop), 32'd1);
    cyc("mid", 0, 0, 0, 0, 0, 0);
    cyc("play_fd", 0, 0, 0, 0, 1, 10);
    chk("play_state", 32'(u_if.play_state), 32'd1);
    chk("play_stop", 32'(u_if.rd_stop), 32'd0);

    // Five next keys wrap to file 1; first-cycle frame_done is ignored.
    for (int i = 0; i < 5; i++) cyc("next5", 1, 0, 0, 0, 0, 0);
    chk("next5_file", 32'(u_if.file_idx), 32'd1);
    chk("next5_addr", u_if.rd_addr_setting, 32'd1481040);
    cyc("sw_fd1", 0, 0, 0, 0, 1, 3);
    chk("sw_reset_held", 32'(u_if.rd_addr_reset), 32'd1);
    cyc("sw_fd2", 0, 0, 0, 0, 1, 0);
    chk("sw_exit", 32'(u_if.play_state), 32'd1);
    chk("sw_reset_drop", 32'(u_if.rd_addr_reset), 32'd0);

    // Retro, then frame 0 at the boundary pauses.
    cyc("retro_key", 0, 0, 0, 1, 0, 0);
    cyc("retro_fd", 0, 0, 0, 0, 1, 50);
    chk("retro_on", 32'(u_if.rd_retro), 32'd1);
    cyc("retro_zero", 0, 0, 0, 0, 1, 0);
    chk("retro_pause", 32'(u_if.play_state), 32'd0);
    chk("retro_off", 32'(u_if.rd_retro), 32'd0);

    // Next and play together: only the switch happens.
    cyc("next_play", 1, 0, 1, 0, 0, 0);
    chk("np_pend", 32'(u_if.cmd_pending), 32'd0);
    chk("np_state", 32'(u_if.play_state), 32'd3);
    cyc("np_fd1", 0, 0, 0, 0, 1, 0);
    cyc("np_fd2", 0, 0, 0, 0, 1, 0);

    // Key on a boundary: old target applies, new one stays pending.
    cyc("coin_key", 0, 0, 1, 0, 0, 0);
    cyc("coin_fd", 0, 0, 0, 1, 1, 20);
    chk("coin_state", 32'(u_if.play_state), 32'd0);
    chk("coin_pend", 32'(u_if.cmd_pending), 32'd1);
    cyc("coin_fd2", 0, 0, 0, 0, 1, 21);
    chk("coin_retro", 32'(u_if.play_state), 32'd2);

    // Reach PLAY on file 3, then hit the last frame.
    cyc("to3", 1, 0, 0, 0, 0, 0);
    cyc("to3_w", 0, 0, 0, 0, 0, 0);
    cyc("to3_fd", 0, 0, 0, 0, 1, 0);
    cyc("last_fd", 0, 0, 0, 0, 1, FRAME_MAX - 1);
`ifdef SD_PLAY_AUTO_NEXT_EN
    chk("auto_file", 32'(u_if.file_idx), 32'd0);
    chk("auto_addr", u_if.rd_addr_setting, 32'd0);
`else
    chk("loop_file", 32'(u_if.file_idx), 32'd3);
`endif
    chk("auto_noreset", 32'(u_if.rd_addr_reset), 32'd0);

    // Reset in the middle of a switch.
    cyc("pre_rst", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      kn = 0; kp = 0; kpl = 0; kr = 0;
      kind = int'($urandom_range(0, 15));
      case (kind)
        0: kn = 1;
        1: kp = 1;
        2: kpl = 1;
        3: kr = 1;
        4: {kn, kp, kpl, kr} = 4'($urandom_range(0, 15));
        default: ;
      endcase
      fd = ($urandom_range(0, 4) == 0);
      if (fd) begin
        kn = 0;
        kp = 0;
      end
      case ($urandom_range(0, 3))
        0: cnt = 0;
        1: cnt = FRAME_MAX - 1;
        default: cnt = int'($urandom_range(0, FRAME_MAX - 1));
      endcase
      cyc("rand", kn, kp, kpl, kr, fd, cnt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sd_play_sched.md
# sd_play_sched

Playback scheduler sitting in front of the SD frame read controller. It turns debounced user key pulses (play/pause, retro, next/prev file) into the `rd_stop`, `rd_retro`, `rd_addr_reset` and `rd_addr_setting` controls of the read controller. Mode changes are applied only at frame boundaries so the read controller sees stable controls across its end-of-frame decision. It also computes the start sector of each video file on the card.

## Interface
- `FILE_NUM`, 4: number of video files on the card, range 1..16.
- `FILE_BASE`, 32'd0: start sector of file 0.
- `FILE_STRIDE`, 32'd1481040: sectors per file (8228 × 180).
- `FRAME_MAX`, 180: frames per file.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_play` in 1: one-cycle pulse, toggles play/pause.
- `key_retro` in 1: one-cycle pulse, toggles reverse play.
- `key_next` in 1: one-cycle pulse, selects the next file.
- `key_prev` in 1: one-cycle pulse, selects the previous file.
- `frame_done` in 1: one-cycle end-of-frame pulse from the read controller (its `bin_read_over`).
- `read_frame_cnt` in 8: current frame index from the read controller.
- `rd_addr_setting` out 32: start sector of the selected file.
- `rd_addr_reset` out 1: request that the read controller reload `rd_addr_setting`.
- `rd_stop` out 1: repeat the current frame.
- `rd_retro` out 1: step back one frame per frame period.
- `file_idx` out 4: selected file.
- `play_state` out 2: 0 = PAUSE, 1 = PLAY, 2 = RETRO, 3 = SWITCH.
- `cmd_pending` out 1: a mode command is waiting for a frame boundary.

## Operation
- All outputs are registered.
- Reset values:
  - state PAUSE, `file_idx` 0, `rd_addr_setting` = `FILE_BASE`.
  - `rd_stop` 1, `rd_retro` 0, `rd_addr_reset` 0, `cmd_pending` 0.
- Output decode by state: PAUSE gives `rd_stop`=1; RETRO gives `rd_retro`=1; PLAY gives both 0; SWITCH gives both 0 and `rd_addr_reset`=1.
- Start address is `FILE_BASE + file_idx*FILE_STRIDE`, computed modulo 2^32 in 32-bit arithmetic.
- Key priority when keys arrive in the same cycle: next > prev > play > retro. Lower-priority keys in that cycle are dropped.
- File keys act immediately, with no frame-boundary wait:
  - `file_idx` is updated, wrapping: next from FILE_NUM−1 goes to 0; prev from 0 goes to FILE_NUM−1.
  - `rd_addr_setting` is recomputed, `rd_addr_reset` is asserted, and the state enters SWITCH.
  - A file key while already in SWITCH re-targets and restarts the SWITCH age.
- Mode keys compute a target mode:
  - The target is derived from the pending target if one exists, otherwise from the current state.
  - `key_play`: PLAY→PAUSE, PAUSE→PLAY, RETRO→PLAY.
  - `key_retro`: RETRO→PLAY, PLAY→RETRO, PAUSE→RETRO.
  - The target is stored in a single pending register; a newer command overwrites an older one. `cmd_pending` is set.
- At a frame boundary (`frame_done`=1, state ≠ SWITCH):
  - If a command is pending, the state takes the target and `cmd_pending` clears.
  - Else, if state is RETRO and `read_frame_cnt`=0, the state goes to PAUSE.
- SWITCH exit:
  - `frame_done` in the first SWITCH cycle is ignored, because the read controller samples the reset request one cycle late.
  - On a later `frame_done`, the state goes to PLAY and `rd_addr_reset` drops.
  - A command that is still pending is applied at the next boundary after exit.

## Timing
- Key to `cmd_pending` (or to SWITCH outputs): 1 cycle.
- `frame_done` sampled at edge N → new `rd_stop`/`rd_retro` visible from edge N. They then stay stable for the whole next frame.
- `rd_addr_reset` is high for at least 2 cycles and always covers the cycle in which the read controller samples `frame_done`.
- Key coinciding with `frame_done`:
  - The boundary applies the old pending target.
  - The new key becomes pending for the following boundary.
- Reset mid-SWITCH returns to PAUSE with file 0. The file-0 address is presented immediately.

## Configuration
- `SD_PLAY_AUTO_NEXT_EN` defined:
  - Condition: state PLAY, no pending command, `frame_done`=1 and `read_frame_cnt`=FRAME_MAX−1.
  - Action: `file_idx` advances (with wrap) and `rd_addr_setting` updates on that edge. The read controller's end-of-file reload then picks up the next file with no SWITCH state.
- Undefined: the file loops; `rd_addr_setting` changes only on file keys.

## Test plan
- Reset release → PAUSE, `rd_stop`=1, `rd_addr_setting`=0, `file_idx`=0; no output change until a key arrives.
- `key_play` mid-frame → `cmd_pending`=1 and `rd_stop` still 1; next `frame_done` → PLAY, `rd_stop`=0, `cmd_pending`=0.
- `key_next` ×5 with FILE_NUM=4 → `file_idx`=1, `rd_addr_setting`=1481040. `rd_addr_reset` is held through the second `frame_done` after entry, then PLAY.
- RETRO with `read_frame_cnt`=0 at `frame_done` → PAUSE, `rd_retro`=0, `rd_stop`=1.
- `key_next` and `key_play` in the same cycle → only the file switch occurs; `cmd_pending` stays 0.
- With `SD_PLAY_AUTO_NEXT_EN`: PLAY file 3, `frame_done` with cnt=179 → `file_idx`=0, `rd_addr_setting`=0 on the next cycle, `rd_addr_reset` never asserted.
